// File: rtl/qpsk_symbol_mapper_if.sv
// Byte-stream handshake into the symbol mapper.
// Ports: din (payload byte), din_valid, din_ready.
interface qpsk_symbol_mapper_if;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/qpsk_symbol_mapper.sv
// Serialises bytes MSB-first into QPSK (Gray) or 2ASK symbols.
// Ports: clk50m, rst_n (async low), sym_clk (sampled symbol clock),
//        en, feed (byte handshake, slave), i_out/q_out (signed levels),
//        phase_sel (carrier phase index), sym_strobe, underrun.
module qpsk_symbol_mapper #(
    parameter int MODE  = 0,
    parameter int OUT_W = 8,
    parameter int AMP   = 100
) (
    input  logic                    clk50m,
    input  logic                    rst_n,
    input  logic                    sym_clk,
    input  logic                    en,
    qpsk_symbol_mapper_if.slave     feed,
    output logic signed [OUT_W-1:0] i_out,
    output logic signed [OUT_W-1:0] q_out,
    output logic [1:0]              phase_sel,
    output logic                    sym_strobe,
    output logic                    underrun
);

    localparam int BPS = (MODE == 1) ? 1 : 2;
    localparam logic [3:0] SPB = (MODE == 1) ? 4'd8 : 4'd4;
    localparam logic signed [OUT_W-1:0] POS = OUT_W'(AMP);
    localparam logic signed [OUT_W-1:0] NEG = -POS;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;

    logic s1, s2, s3;
    logic tick;
    logic [7:0] hold;
    logic hold_full;
    logic [7:0] sh;
    logic [3:0] sym_left;

    logic accept;
    logic have;
    logic [7:0] src;
    logic [7:0] src_nxt;
    logic signed [OUT_W-1:0] m_i;
    logic signed [OUT_W-1:0] m_q;
    logic [1:0] m_ph;

    // Rising edge of the synchronised symbol clock, gated by enable.
    assign tick = s2 & ~s3 & en;

    assign feed.din_ready = ~hold_full;
    assign accept = feed.din_valid & ~hold_full;

    // Bits still in the shifter take priority over the held byte.
    assign have    = (sym_left != 4'd0) | hold_full;
    assign src     = (sym_left != 4'd0) ? sh : hold;
    assign src_nxt = src << BPS;

    always_comb begin
        m_i  = POS;
        m_q  = POS;
        m_ph = 2'd0;
        if (MODE == 1) begin
            m_i = src[7] ? POS : '0;
            m_q = '0;
        end else begin
            // Gray dibit b1b0: I sign from b0, Q sign from b1.
            m_i  = src[6] ? NEG : POS;
            m_q  = src[7] ? NEG : POS;
            m_ph = {src[7], src[7] ^ src[6]};
        end
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            hold       <= 8'd0;
            hold_full  <= 1'b0;
            sh         <= 8'd0;
            sym_left   <= 4'd0;
            state      <= IDLE;
            i_out      <= '0;
            q_out      <= '0;
            phase_sel  <= 2'd0;
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            s1         <= sym_clk;
            s2         <= s1;
            s3         <= s2;
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;

            // Accept needs an empty holder, transfer needs a full one,
            // so the two never collide on hold_full.
            if (accept) begin
                hold      <= feed.din;
                hold_full <= 1'b1;
            end

            if (tick) begin
                if (have) begin
                    sh <= src_nxt;
                    if (sym_left != 4'd0) begin
                        sym_left <= sym_left - 4'd1;
                    end else begin
                        sym_left  <= SPB - 4'd1;
                        hold_full <= 1'b0;
                    end
                    i_out      <= m_i;
                    q_out      <= m_q;
                    phase_sel  <= m_ph;
                    sym_strobe <= 1'b1;
                    state      <= RUN;
                end else if (state == RUN) begin
                    // Starved: silence the carrier, keep the phase.
                    i_out      <= '0;
                    q_out      <= '0;
                    sym_strobe <= 1'b1;
                    underrun   <= 1'b1;
                    state      <= IDLE;
                end
            end
        end
    end

endmodule
